// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: parses HDR0 HDR1 CH PAYLOAD CSUM TAIL frames
// and applies per-channel enable/interval updates, with inter-byte timeout.
module uart_cmd_decoder #(
  parameter int          N_CH          = 4,
  parameter int          PAYLOAD_BYTES = 2,
  parameter logic [7:0]  HDR0          = 8'hEE,
  parameter logic [7:0]  HDR1          = 8'hDD,
  parameter logic [7:0]  TAIL_EN       = 8'hCC,
  parameter logic [7:0]  TAIL_DIS      = 8'hBB,
  parameter logic [7:0]  BCAST         = 8'hFF,
  parameter int          TIMEOUT_CYC   = 50000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wen,
  input  logic [7:0]                        din,
  output logic [N_CH-1:0]                   enable,
  output logic [N_CH*8*PAYLOAD_BYTES-1:0]   interval,
  output logic                              frame_ok,
  output logic                              frame_err,
  output logic [2:0]                        err_code
);

  localparam int IW = 8 * PAYLOAD_BYTES;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam int TW = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_EN ? TIMEOUT_CYC - 1 : 0);
  localparam logic [1:0] PAY_LAST = 2'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_HDR1 = 3'd1,
    S_CH   = 3'd2,
    S_PAY  = 3'd3,
    S_CSUM = 3'd4,
    S_TAIL = 3'd5
  } state_t;

  state_t                 state_r, next_state_s;
  logic [7:0]             ch_r, acc_r;
  logic [IW-1:0]          pay_r;
  logic [1:0]             cnt_r;
  logic                   csum_ok_r;
  logic [TW-1:0]          to_cnt_r;
  logic                   timeout_s;
  logic                   tail_en_s, tail_dis_s;
  logic [N_CH-1:0]        enable_nx_s;
  logic [N_CH*IW-1:0]     interval_nx_s;
  logic                   ok_nx_s, err_nx_s;
  logic [2:0]             code_nx_s;

  // Expiry fires on the idle cycle that would bring the counter to TIMEOUT_CYC.
  assign timeout_s  = TO_EN && (state_r != IDLE) && !wen && (to_cnt_r == TO_LAST);
  assign tail_en_s  = (din == TAIL_EN);
  assign tail_dis_s = (din == TAIL_DIS);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic; timeout overrides byte handling.
  always_comb begin
    next_state_s = state_r;
    if (timeout_s) begin
      next_state_s = IDLE;
    end else if (wen) begin
      case (state_r)
        IDLE:   next_state_s = (din == HDR0) ? S_HDR1 : IDLE;
        S_HDR1: begin
          if (din == HDR1)      next_state_s = S_CH;
          else if (din == HDR0) next_state_s = S_HDR1;
          else                  next_state_s = IDLE;
        end
        S_CH:   next_state_s = S_PAY;
        S_PAY:  next_state_s = (cnt_r == PAY_LAST) ? S_CSUM : S_PAY;
        S_CSUM: next_state_s = S_TAIL;
        S_TAIL: next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Next values of the registered outputs: tail evaluation and timeout reporting.
  always_comb begin
    enable_nx_s   = enable;
    interval_nx_s = interval;
    ok_nx_s       = 1'b0;
    err_nx_s      = 1'b0;
    code_nx_s     = err_code;
    if (timeout_s) begin
      err_nx_s  = 1'b1;
      code_nx_s = 3'd4;
    end else if ((state_r == S_TAIL) && wen) begin
      if (!tail_en_s && !tail_dis_s) begin
        err_nx_s  = 1'b1;
        code_nx_s = 3'd1;
      end else if (!csum_ok_r) begin
        err_nx_s  = 1'b1;
        code_nx_s = 3'd2;
      end else if ((ch_r >= 8'(N_CH)) && (ch_r != BCAST)) begin
        err_nx_s  = 1'b1;
        code_nx_s = 3'd3;
      end else begin
        ok_nx_s = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          if ((ch_r == BCAST) || (ch_r == 8'(i))) begin
            enable_nx_s[i]             = tail_en_s;
            interval_nx_s[i*IW +: IW]  = tail_en_s ? pay_r : {IW{1'b0}};
          end else begin
            enable_nx_s[i] = enable[i];
          end
        end
      end
    end else begin
      ok_nx_s = 1'b0;
    end
  end

  // Frame datapath: channel, payload shift register, checksum accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_r      <= 8'd0;
      acc_r     <= 8'd0;
      pay_r     <= {IW{1'b0}};
      cnt_r     <= 2'd0;
      csum_ok_r <= 1'b0;
    end else if (wen) begin
      case (state_r)
        S_CH: begin
          ch_r  <= din;
          acc_r <= din;
          cnt_r <= 2'd0;
        end
        S_PAY: begin
          pay_r <= IW'({pay_r, din});
          acc_r <= acc_r ^ din;
          cnt_r <= cnt_r + 2'd1;
        end
        S_CSUM:  csum_ok_r <= (din == acc_r);
        default: ch_r <= ch_r;
      endcase
    end
  end

  // Inter-byte timeout counter, held at zero outside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         to_cnt_r <= {TW{1'b0}};
    else if (!TO_EN || state_r == IDLE || wen || timeout_s) to_cnt_r <= {TW{1'b0}};
    else                                                to_cnt_r <= to_cnt_r + TW'(1);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= {N_CH{1'b0}};
      interval  <= {(N_CH*IW){1'b0}};
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      enable    <= enable_nx_s;
      interval  <= interval_nx_s;
      frame_ok  <= ok_nx_s;
      frame_err <= err_nx_s;
      err_code  <= code_nx_s;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder (3 channels, 2-byte payload, 20-cycle timeout):
// a byte-queue frame model checked every cycle, plus literal spot checks.
module tb_uart_cmd_decoder;

  localparam int NC = 3;
  localparam int PB = 2;
  localparam int IW = 8 * PB;
  localparam int TO = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wen;
  logic [7:0]        din;
  logic [NC-1:0]     enable;
  logic [NC*IW-1:0]  interval;
  logic              frame_ok, frame_err;
  logic [2:0]        err_code;

  uart_cmd_decoder #(.N_CH(NC), .PAYLOAD_BYTES(PB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din),
    .enable(enable), .interval(interval),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  bit chk_on = 1'b0;

  // Model state: expected outputs plus the bytes of the frame in progress.
  logic [NC-1:0]     m_en;
  logic [NC*IW-1:0]  m_iv;
  logic              m_ok, m_ferr;
  logic [2:0]        m_code;
  logic [7:0]        q[$];
  int                idle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_en = '0; m_iv = '0; m_ok = 1'b0; m_ferr = 1'b0; m_code = 3'd0;
    q.delete(); idle = 0;
  endtask

  task automatic model_reject(input logic [2:0] code);
    m_ferr = 1'b1;
    m_code = code;
  endtask

  task automatic model_tail(input logic [7:0] tail);
    logic [7:0]    ch, x;
    logic [IW-1:0] pay;
    ch = q[2];
    x = 8'd0;
    pay = '0;
    for (int k = 0; k <= PB; k++) x = x ^ q[2+k];
    for (int k = 0; k < PB; k++) pay = (pay << 8) | IW'(q[3+k]);
    if (tail != 8'hCC && tail != 8'hBB) model_reject(3'd1);
    else if (x != q[3+PB])              model_reject(3'd2);
    else if (ch >= NC && ch != 8'hFF)   model_reject(3'd3);
    else begin
      m_ok = 1'b1;
      for (int i = 0; i < NC; i++)
        if (ch == 8'hFF || ch == i) begin
          m_en[i] = (tail == 8'hCC);
          m_iv[i*IW +: IW] = (tail == 8'hCC) ? pay : '0;
        end
    end
  endtask

  task automatic model_step(input logic w, input logic [7:0] b);
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_ok = 1'b0;
    m_ferr = 1'b0;
    if (w) begin
      idle = 0;
      if (q.size() == 0) begin
        if (b == 8'hEE) q.push_back(b);
      end else if (q.size() == 1) begin
        if (b == 8'hDD) q.push_back(b);
        else if (b != 8'hEE) q.delete();
      end else if (q.size() < 4 + PB) begin
        q.push_back(b);
      end else begin
        model_tail(b);
        q.delete();
      end
    end else if (q.size() > 0) begin
      idle++;
      if (idle >= TO) begin
        model_reject(3'd4);
        q.delete();
        idle = 0;
      end
    end
  endtask

  // One clock cycle of stimulus; the model consumes the same inputs at the edge.
  task automatic cyc(input logic w, input logic [7:0] b);
    wen = w;
    din = b;
    @(posedge clk);
    model_step(w, b);
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
  endtask

  task automatic frame(input logic [55:0] f);
    for (int k = 6; k >= 0; k--) send(f[k*8 +: 8]);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on)
      check("cycle_outputs", 64'({enable, interval, frame_ok, frame_err, err_code}),
            64'({m_en, m_iv, m_ok, m_ferr, m_code}));
  end

  initial begin
    rst_n = 1'b0;
    wen = 1'b0;
    din = 8'h00;
    model_reset();
    @(negedge clk);
    chk_on = 1'b1;
    idle_n(2);
    check("reset_outputs", 64'({enable, interval, frame_ok, frame_err, err_code}), 64'd0);
    rst_n = 1'b1;
    idle_n(2);

    // Enable ch2.
    frame(56'hEEDD02123424CC);
    check("ch2_enable", 64'(enable), 64'(3'b100));
    check("ch2_interval", 64'(interval), 64'(48'h1234_0000_0000));
    check("ch2_ok_pulse", 64'({frame_ok, frame_err}), 64'(2'b10));
    check("model_pin_en", 64'(m_en), 64'(3'b100));
    idle_n(1);
    check("ok_one_cycle", 64'(frame_ok), 64'd0);

    // Enable ch0, then broadcast disable back-to-back.
    frame(56'hEEDD00ABCD66CC);
    check("ch0_enable", 64'(enable), 64'(3'b101));
    frame(56'hEEDDFF0000FFBB);
    check("bcast_dis", 64'({enable, interval}), 64'd0);
    check("bcast_ok", 64'(frame_ok), 64'd1);

    // Bad checksum, then bad channel.
    frame(56'hEEDD01001000CC);
    check("csum_err", 64'({frame_ok, frame_err, err_code}), 64'({1'b0, 1'b1, 3'd2}));
    frame(56'hEEDD03ABCD65CC);
    check("chan_err", 64'({frame_err, err_code}), 64'({1'b1, 3'd3}));
    idle_n(1);
    check("err_code_hold", 64'({frame_err, err_code}), 64'({1'b0, 3'd3}));
    check("err_no_change", 64'({enable, interval}), 64'd0);

    // Garbage and repeated header before a valid frame.
    send(8'h55); send(8'hEE);
    frame(56'hEEDD01006465CC);
    check("resync_en", 64'(enable), 64'(3'b010));
    check("resync_iv1", 64'(interval[IW +: IW]), 64'(16'h0064));
    frame(56'hEEDD001122335A);
    check("tail_err", 64'({frame_err, err_code, enable}), 64'({1'b1, 3'd1, 3'b010}));

    // Timeout after CH byte.
    send(8'hEE); send(8'hDD); send(8'h01);
    idle_n(TO - 1);
    check("no_early_timeout", 64'(frame_err), 64'd0);
    idle_n(1);
    check("timeout_err", 64'({frame_err, err_code, enable}), 64'({1'b1, 3'd4, 3'b010}));
    frame(56'hEEDD00000707CC);
    check("after_timeout", 64'({frame_ok, enable}), 64'({1'b1, 3'b011}));

    // Byte arriving exactly at the expiry cycle is processed.
    send(8'hEE); send(8'hDD); send(8'h02);
    idle_n(TO - 1);
    send(8'h00);
    check("edge_no_err", 64'(frame_err), 64'd0);
    send(8'h05); send(8'h07); send(8'hCC);
    check("edge_frame_ok", 64'({frame_ok, enable}), 64'({1'b1, 3'b111}));
    check("edge_iv2", 64'(interval[2*IW +: IW]), 64'(16'h0005));

    // Asynchronous reset mid-frame.
    send(8'hEE); send(8'hDD); send(8'h00); send(8'h12);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset", 64'({enable, interval, frame_ok, frame_err, err_code}), 64'd0);
    @(negedge clk);
    idle_n(1);
    rst_n = 1'b1;
    idle_n(1);
    frame(56'hEEDD01006465CC);
    check("post_reset", 64'({frame_ok, enable, interval}),
          64'({1'b1, 3'b010, 48'h0000_0064_0000}));
    idle_n(3);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Byte-stream command decoder that sits behind the UART receiver and drives per-channel enable/interval controls.
- Parametrised in channel count and payload width.
- Frames carry a channel address, an XOR checksum and an enable/disable tail.
- Explicit framing FSM with inter-byte timeout, broadcast addressing and error reporting.

Parameters:
- N_CH, 4, number of controlled channels (1..254).
- PAYLOAD_BYTES, 2, interval payload bytes per frame (1..4); IW = 8*PAYLOAD_BYTES.
- HDR0, 8'hEE, first header byte.
- HDR1, 8'hDD, second header byte.
- TAIL_EN, 8'hCC, tail selecting enable/load.
- TAIL_DIS, 8'hBB, tail selecting disable/clear.
- BCAST, 8'hFF, broadcast channel address.
- TIMEOUT_CYC, 50000, max clk cycles between bytes inside a frame; 0 disables timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wen  in  1  byte strobe, one cycle per received byte.
- din  in  8  received byte, valid when wen=1.
- enable  out  N_CH  per-channel enable, bit i = channel i.
- interval  out  N_CH*IW  per-channel interval; channel i occupies [i*IW +: IW].
- frame_ok  out  1  one-cycle pulse: valid frame applied.
- frame_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  3  cause of last rejection; holds until next rejection.

Behaviour:
- Reset (async, rst_n=0): enable=0, interval=0, frame_ok=0, frame_err=0, err_code=0, FSM=IDLE, timeout counter=0, checksum accumulator=0.
- Frame format, in order: HDR0, HDR1, CH, PAYLOAD (PAYLOAD_BYTES bytes, MSB first), CSUM, TAIL.
  - CSUM = XOR of CH and all payload bytes.
- FSM states and transitions (advance only on wen=1):
  - IDLE: HDR0 -> S_HDR1; any other byte ignored.
  - S_HDR1: HDR1 -> S_CH. Else if byte==HDR0, stay in S_HDR1 (resync). Else -> IDLE, silently with no error.
  - S_CH: latch CH, init accumulator = CH, clear byte counter -> S_PAY.
  - S_PAY: shift byte into payload register, XOR into accumulator. After PAYLOAD_BYTES bytes -> S_CSUM.
  - S_CSUM: latch csum_ok = (byte == accumulator) -> S_TAIL.
  - S_TAIL: evaluate the frame, then -> IDLE.
- Tail evaluation, first matching rule wins:
  - tail not TAIL_EN and not TAIL_DIS -> err 3'd1.
  - !csum_ok -> err 3'd2.
  - CH >= N_CH and CH != BCAST -> err 3'd3.
  - Otherwise accept.
- On accept:
  - TAIL_EN: enable[CH]=1, interval[CH]=payload.
  - TAIL_DIS: enable[CH]=0, interval[CH]=0.
  - BCAST applies to all channels.
  - Untargeted channels hold their values.
- Latency: outputs update and frame_ok (or frame_err with err_code) assert on the clock edge sampling the tail wen. Each pulse lasts exactly one cycle. frame_ok and frame_err are never asserted together.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle without wen and clears on wen. It is held at 0 in IDLE.
  - When the counter reaches TIMEOUT_CYC: go to IDLE, pulse frame_err, set err_code=3'd4. enable and interval are unchanged.
  - If wen arrives in the same cycle the counter would expire, the byte is processed and the counter clears.
  - TIMEOUT_CYC=0: counter is inert.
  - Counter width = $clog2(TIMEOUT_CYC+1), minimum 1.
- HDR0 appearing inside the CH/PAY/CSUM fields is treated as data, with no resync.
- Back-to-back frames: a new HDR0 on the byte immediately after a tail is accepted.
- Reset mid-frame aborts the frame and clears all outputs.
- wen is treated as a single-cycle strobe. Consecutive-cycle wen are each consumed as separate bytes.

Test Plan:
- Enable ch2: EE DD 02 12 34 24 CC -> enable=4'b0100, interval[2]=16'h1234, frame_ok one pulse, other intervals 0.
- Broadcast disable after enabling ch0 and ch2: EE DD FF 00 00 FF BB -> enable=0, all intervals 0, frame_ok pulse.
- Bad checksum: EE DD 01 00 10 00 CC -> frame_err pulse, err_code=2, outputs unchanged. Then EE DD 03 AB CD 65 CC (bad channel, N_CH=3 build) -> err_code=3.
- Resync/garbage: 55 EE EE DD 01 00 64 65 CC -> enable[1]=1, interval[1]=16'h0064. Tail 5A on otherwise valid frame -> err_code=1.
- Timeout (TIMEOUT_CYC=20): EE DD 01 then 20 idle cycles -> frame_err at cycle 20, err_code=4, FSM IDLE. Following full valid frame accepted. Wen arriving at cycle 20 -> no error.
- Reset mid-frame: send EE DD 00 12, assert rst_n=0 asynchronously -> all outputs 0 immediately. After release, a fresh valid frame is applied normally.
